// File: rtl/carry_bitstream_serializer_pkg.sv
// Shared types for the carry bitstream serializer: bundle flags, FSM states,
// the buffered bundle payload and the end-of-bundle decode.
package carry_ser_pkg;

    localparam int unsigned SER_BITSTREAM_WIDTH = 8;
    localparam int unsigned FLAG_WIDTH          = 3;
    localparam int unsigned STATE_WIDTH         = 3;

    localparam logic [FLAG_WIDTH-1:0] FLAG_NONE         = 3'd0;
    localparam logic [FLAG_WIDTH-1:0] FLAG_B1           = 3'd1;
    localparam logic [FLAG_WIDTH-1:0] FLAG_B1_B2        = 3'd2;
    localparam logic [FLAG_WIDTH-1:0] FLAG_B1_B3        = 3'd3;
    localparam logic [FLAG_WIDTH-1:0] FLAG_B1_B4        = 3'd4;
    localparam logic [FLAG_WIDTH-1:0] FLAG_B1_RUN       = 3'd5;
    localparam logic [FLAG_WIDTH-1:0] FLAG_B1_RUN_B4    = 3'd6;
    localparam logic [FLAG_WIDTH-1:0] FLAG_B1_RUN_B4_B5 = 3'd7;

    typedef logic [STATE_WIDTH-1:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_B1   = 3'd1;
    localparam state_t ST_B2   = 3'd2;
    localparam state_t ST_B3   = 3'd3;
    localparam state_t ST_RUN  = 3'd4;
    localparam state_t ST_B4   = 3'd5;
    localparam state_t ST_B5   = 3'd6;

    typedef struct packed {
        logic [FLAG_WIDTH-1:0]          flag;
        logic [SER_BITSTREAM_WIDTH-1:0] b1;
        logic [SER_BITSTREAM_WIDTH-1:0] b2;
        logic [SER_BITSTREAM_WIDTH-1:0] b3;
        logic [SER_BITSTREAM_WIDTH-1:0] b4;
        logic [SER_BITSTREAM_WIDTH-1:0] b5;
        logic                           last;
    } bundle_t;

    // True when the byte presented in this state is the bundle's final byte.
    function automatic logic is_final_byte(
        input state_t                         state,
        input logic [FLAG_WIDTH-1:0]          flag,
        input logic [SER_BITSTREAM_WIDTH-1:0] b3,
        input logic [SER_BITSTREAM_WIDTH-1:0] run_cnt
    );
        logic fin;
        fin = 1'b0;
        case (state)
            ST_B1:   fin = (flag == FLAG_B1) ||
                           ((flag == FLAG_B1_RUN) && (b3 == '0));
            ST_B2:   fin = (flag == FLAG_B1_B2);
            ST_B3:   fin = (flag == FLAG_B1_B3);
            ST_RUN:  fin = (flag == FLAG_B1_RUN) &&
                           (run_cnt == SER_BITSTREAM_WIDTH'(1));
            ST_B4:   fin = (flag == FLAG_B1_B4) || (flag == FLAG_B1_RUN_B4);
            ST_B5:   fin = 1'b1;
            default: fin = 1'b0;
        endcase
        return fin;
    endfunction

endpackage

// File: rtl/carry_bundle_fifo.sv
// Single-clock FIFO of carry bundles with a registered occupancy count and a
// combinational head-of-queue view.
module carry_bundle_fifo
    import carry_ser_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  bundle_t             wr_data,
    output bundle_t             head,
    output logic                full,
    output logic                empty,
    output logic [ADDR_WIDTH:0] count
);

    bundle_t               mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == (ADDR_WIDTH + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/carry_bitstream_serializer.sv
// Buffers flag-encoded carry bundles and expands them, run-length repeats
// included, into a one-byte-per-beat valid/ready stream.
module carry_bitstream_serializer
    import carry_ser_pkg::*;
#(
    parameter int unsigned SER_FIFO_DEPTH      = 8,
    parameter int unsigned SER_FIFO_ADDR_WIDTH = 3
) (
    input  logic                           ser_clk,
    input  logic                           ser_reset,
    input  logic [SER_BITSTREAM_WIDTH-1:0] in_carry_bit_1,
    input  logic [SER_BITSTREAM_WIDTH-1:0] in_carry_bit_2,
    input  logic [SER_BITSTREAM_WIDTH-1:0] in_carry_bit_3,
    input  logic [SER_BITSTREAM_WIDTH-1:0] in_carry_bit_4,
    input  logic [SER_BITSTREAM_WIDTH-1:0] in_carry_bit_5,
    input  logic [2:0]                     in_carry_flag,
    input  logic                           in_flag_last,
    output logic                           in_ready,
    output logic [SER_BITSTREAM_WIDTH-1:0] out_byte,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           overflow_error
);

    bundle_t                        in_bundle;
    bundle_t                        head;
    logic                           push;
    logic                           pop;
    logic                           full;
    logic                           empty;
    logic [SER_FIFO_ADDR_WIDTH:0]   count;
    state_t                         state;
    state_t                         state_next;
    logic [SER_BITSTREAM_WIDTH-1:0] run_cnt;
    logic [SER_BITSTREAM_WIDTH-1:0] run_cnt_next;
    logic                           beat;
    logic                           final_byte;
    logic                           more_queued;

    assign in_bundle = '{flag: in_carry_flag, b1: in_carry_bit_1, b2: in_carry_bit_2,
                         b3: in_carry_bit_3, b4: in_carry_bit_4, b5: in_carry_bit_5,
                         last: in_flag_last};

    assign in_ready    = !full;
    assign push        = (in_carry_flag != FLAG_NONE) && !full;
    assign out_valid   = (state != ST_IDLE);
    assign beat        = out_valid && out_ready;
    assign final_byte  = is_final_byte(state, head.flag, head.b3, run_cnt);
    assign pop         = beat && final_byte;
    assign out_last    = out_valid && head.last && final_byte;
    assign more_queued = (count > (SER_FIFO_ADDR_WIDTH + 1)'(1)) || push;

    carry_bundle_fifo #(
        .DEPTH      (SER_FIFO_DEPTH),
        .ADDR_WIDTH (SER_FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (ser_clk),
        .reset   (ser_reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_bundle),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge ser_clk) begin
        if (ser_reset) begin
            state          <= ST_IDLE;
            run_cnt        <= '0;
            overflow_error <= 1'b0;
        end else begin
            state   <= state_next;
            run_cnt <= run_cnt_next;
            if ((in_carry_flag != FLAG_NONE) && full) begin
                overflow_error <= 1'b1;
            end
        end
    end

    // Expander: walks the head bundle one byte per beat, holding without a beat.
    always_comb begin
        state_next   = state;
        run_cnt_next = run_cnt;
        if (state == ST_IDLE) begin
            if (!empty || push) begin
                state_next = ST_B1;
            end
        end else if (beat) begin
            if (final_byte) begin
                state_next = more_queued ? ST_B1 : ST_IDLE;
            end else begin
                case (state)
                    ST_B1: begin
                        if (head.flag <= FLAG_B1_B4) begin
                            state_next = ST_B2;
                        end else if (head.b3 != '0) begin
                            state_next   = ST_RUN;
                            run_cnt_next = head.b3;
                        end else begin
                            state_next = ST_B4;
                        end
                    end
                    ST_B2:   state_next = ST_B3;
                    ST_B3:   state_next = ST_B4;
                    ST_RUN: begin
                        if (run_cnt == SER_BITSTREAM_WIDTH'(1)) begin
                            state_next = ST_B4;
                        end else begin
                            run_cnt_next = run_cnt - SER_BITSTREAM_WIDTH'(1);
                        end
                    end
                    ST_B4:   state_next = ST_B5;
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        out_byte = '0;
        case (state)
            ST_B1:   out_byte = head.b1;
            ST_B2:   out_byte = head.b2;
            ST_B3:   out_byte = head.b3;
            ST_RUN:  out_byte = head.b2;
            ST_B4:   out_byte = head.b4;
            ST_B5:   out_byte = head.b5;
            default: out_byte = '0;
        endcase
    end

endmodule
